// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice reused over
// WIDTH/CHUNK cycles with a registered inter-chunk carry, valid/ready on both sides.
module seq_chunk_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             b_en,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STEPS  = WIDTH / CHUNK;
   localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int unsigned CW1    = CHUNK + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                        state;
   state_t                        state_next;
   logic [STEP_W-1:0]             step;
   logic                          carry;
   logic [STEPS-1:0][CHUNK-1:0]   a_q;
   logic [STEPS-1:0][CHUNK-1:0]   b_q;
   logic [STEPS-1:0][CHUNK-1:0]   sum_q;
   logic [WIDTH-1:0]              b_gated;
   logic [CHUNK:0]                chunk_res;
   logic                          msb_cin;
   logic                          last_step;

   assign sum       = sum_q;
   assign b_gated   = b_en ? b : '0;
   assign last_step = (step == STEP_W'(STEPS - 1));

   // Shared slice: current chunk of A, B' and the running carry.
   assign chunk_res = {1'b0, a_q[step]} + {1'b0, b_q[step]} + CW1'(carry);
   // Carry into the slice MSB recovered from its sum bit.
   assign msb_cin   = a_q[step][CHUNK-1] ^ b_q[step][CHUNK-1] ^ chunk_res[CHUNK-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on accept, one chunk per cycle while running.
   always_ff @(posedge clk) begin
      if (rst) begin
         step  <= '0;
         carry <= 1'b0;
         sum_q <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q   <= a;
         b_q   <= sub ? ~b_gated : b_gated;
         carry <= sub ? 1'b1 : cin;
         step  <= '0;
      end else if (state == RUN) begin
         sum_q[step] <= chunk_res[CHUNK-1:0];
         carry       <= chunk_res[CHUNK];
         if (last_step) begin
            cout <= chunk_res[CHUNK];
            ovf  <= msb_cin ^ chunk_res[CHUNK];
         end else begin
            step <= step + STEP_W'(1);
         end
      end
   end

endmodule
